// File: rtl/dff16_piso_tx.sv
// rtl/dff16_piso_tx.sv - parallel-in serial-out transmitter with load handshake and framing strobes
//
// Captures a WIDTH-bit word on an accepted load and shifts it out one bit per
// enabled clock, framed by FIRST and DONE strobes.
//
// Optional feature: define DFF16_PISO_PARITY_EN to append an even-parity bit
// (XOR of the captured word) after the last data bit.
//
// Parameters:
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports:
//   C           clock, rising edge
//   CLR         asynchronous active-high clear
//   CE          clock enable; when low every register holds
//   D           parallel word to transmit
//   LOAD_VALID  D is valid and requests transmission
//   LOAD_READY  block can accept a word (combinational, state == IDLE)
//   SO          serial data out (registered)
//   SO_VALID    SO carries a data or parity bit this cycle (registered)
//   FIRST       first bit of a frame (registered)
//   BUSY        a frame is in progress (registered)
//   DONE        one-cycle pulse after the last bit (registered)

module dff16_piso_tx #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             SO,
    output logic             SO_VALID,
    output logic             FIRST,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH);

`ifdef DFF16_PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd3
    } state_t;
`endif

    state_t           state;
    // Holds the bits not yet presented; the bit on SO has already left it.
    logic [WIDTH-1:0] sr;
    // Number of bits still to be presented after the one currently on SO.
    logic [CW-1:0]    cnt;
`ifdef DFF16_PISO_PARITY_EN
    logic             par;
`endif

    assign LOAD_READY = (state == ST_IDLE);

    // Bit that leads a word in the configured order.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its lead bit consumed.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state    <= ST_IDLE;
            sr       <= '0;
            cnt      <= '0;
            SO       <= 1'b0;
            SO_VALID <= 1'b0;
            FIRST    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
`ifdef DFF16_PISO_PARITY_EN
            par      <= 1'b0;
`endif
        end else if (CE) begin
            case (state)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    BUSY <= 1'b0;
                    if (LOAD_VALID) begin
                        // The first bit goes straight to SO on the accepting
                        // edge, so sr keeps only the remaining bits.
                        state    <= ST_SHIFT;
                        sr       <= advance(D);
                        cnt      <= CW'(WIDTH - 1);
                        SO       <= lead_bit(D);
                        SO_VALID <= 1'b1;
                        FIRST    <= 1'b1;
                        BUSY     <= 1'b1;
`ifdef DFF16_PISO_PARITY_EN
                        par      <= ^D;
`endif
                    end
                end

                ST_SHIFT: begin
                    FIRST <= 1'b0;
                    if (cnt == '0) begin
`ifdef DFF16_PISO_PARITY_EN
                        state    <= ST_PAR;
                        SO       <= par;
                        SO_VALID <= 1'b1;
`else
                        state    <= ST_DONE;
                        SO       <= 1'b0;
                        SO_VALID <= 1'b0;
                        DONE     <= 1'b1;
`endif
                    end else begin
                        SO  <= lead_bit(sr);
                        sr  <= advance(sr);
                        cnt <= cnt - CW'(1);
                    end
                end

`ifdef DFF16_PISO_PARITY_EN
                ST_PAR: begin
                    state    <= ST_DONE;
                    SO       <= 1'b0;
                    SO_VALID <= 1'b0;
                    DONE     <= 1'b1;
                end
`endif

                ST_DONE: begin
                    // Words offered here wait for the IDLE edge that follows.
                    state <= ST_IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end

                default: begin
                    state    <= ST_IDLE;
                    SO       <= 1'b0;
                    SO_VALID <= 1'b0;
                    FIRST    <= 1'b0;
                    BUSY     <= 1'b0;
                    DONE     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff16_piso_tx.sv
// tb/tb_dff16_piso_tx.sv - directed self-checking bench for dff16_piso_tx
module tb_dff16_piso_tx;

`ifdef DFF16_PISO_PARITY_EN
    localparam int NB = 17;
    localparam int PB = 1;
`else
    localparam int NB = 16;
    localparam int PB = 0;
`endif

    logic        C = 1'b0;
    logic        CLR = 1'b1;
    logic        CE = 1'b1;
    logic [15:0] D = 16'h0000;
    logic        LOAD_VALID = 1'b0;
    logic        LOAD_READY, SO, SO_VALID, FIRST, BUSY, DONE;

    int total = 0;
    int bad = 0;

    logic [31:0] rx;
    int          nbits, nfirst, ndone;
    logic        mon_en;
    logic        hold_so, hold_sv;
    logic [15:0] dat;

    dff16_piso_tx #(.WIDTH(16), .MSB_FIRST(1'b1)) dut (
        .C(C), .CLR(CLR), .CE(CE), .D(D), .LOAD_VALID(LOAD_VALID),
        .LOAD_READY(LOAD_READY), .SO(SO), .SO_VALID(SO_VALID),
        .FIRST(FIRST), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 C = ~C;

    // Collects the serial stream, one sample per enabled edge.
    always @(posedge C) begin
        mon_en = CE;
        #1;
        if (mon_en && !CLR) begin
            if (SO_VALID) begin
                rx = {rx[30:0], SO};
                nbits++;
                if (FIRST) nfirst++;
            end
            if (DONE) ndone++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge C);
            #2;
        end
    endtask

    task automatic clr_mon();
        rx = '0; nbits = 0; nfirst = 0; ndone = 0;
    endtask

    task automatic load(input logic [15:0] w);
        D = w;
        LOAD_VALID = 1'b1;
        step(1);
        LOAD_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (BUSY && k < 100) begin
            step(1);
            k++;
        end
        chk(tag, {31'b0, BUSY}, 32'd0);
    endtask

    task automatic chk_data(input string tag, input logic [15:0] exp);
        dat = 16'(rx >> PB);
        chk(tag, {16'b0, dat}, {16'b0, exp});
        chk({tag, "_nbits"}, nbits, NB);
    endtask

    initial begin
        clr_mon();
        // Reset held with clock running
        step(3);
        chk("rst_so", {31'b0, SO}, 0);
        chk("rst_sv", {31'b0, SO_VALID}, 0);
        chk("rst_busy", {31'b0, BUSY}, 0);
        chk("rst_done", {31'b0, DONE}, 0);
        chk("rst_first", {31'b0, FIRST}, 0);
        chk("rst_ready", {31'b0, LOAD_READY}, 1);
        CLR = 1'b0;
        step(2);
        chk("rel_sv", {31'b0, SO_VALID}, 0);
        chk("rel_ready", {31'b0, LOAD_READY}, 1);

        // 0x1234 full frame with latency and framing checks
        clr_mon();
        load(16'h1234);
        chk("t2_sv", {31'b0, SO_VALID}, 1);
        chk("t2_first", {31'b0, FIRST}, 1);
        chk("t2_so0", {31'b0, SO}, 0);
        chk("t2_busy", {31'b0, BUSY}, 1);
        chk("t2_ready", {31'b0, LOAD_READY}, 0);
        step(15);
        chk("t2_last_sv", {31'b0, SO_VALID}, 1);
        chk("t2_last_first", {31'b0, FIRST}, 0);
`ifdef DFF16_PISO_PARITY_EN
        step(1);
        chk("t2_par_sv", {31'b0, SO_VALID}, 1);
        chk("t2_par_so", {31'b0, SO}, 1);
`endif
        step(1);
        chk("t2_done", {31'b0, DONE}, 1);
        chk("t2_done_sv", {31'b0, SO_VALID}, 0);
        chk("t2_done_busy", {31'b0, BUSY}, 1);
        step(1);
        chk("t2_done_off", {31'b0, DONE}, 0);
        chk("t2_idle_busy", {31'b0, BUSY}, 0);
        chk("t2_idle_ready", {31'b0, LOAD_READY}, 1);
        chk_data("t2_data", 16'h1234);
        chk("t2_nfirst", nfirst, 1);
        chk("t2_ndone", ndone, 1);

        // 0xABCD with CE held low after bit 3
        clr_mon();
        load(16'hABCD);
        step(2);
        hold_so = SO;
        hold_sv = SO_VALID;
        CE = 1'b0;
        step(5);
        chk("t3_hold_so", {31'b0, SO}, {31'b0, hold_so});
        chk("t3_hold_sv", {31'b0, SO_VALID}, {31'b0, hold_sv});
        chk("t3_hold_n", nbits, 3);
        CE = 1'b1;
        wait_idle("t3_timeout");
        chk_data("t3_data", 16'hABCD);
        chk("t3_ndone", ndone, 1);
`ifdef DFF16_PISO_PARITY_EN
        chk("t3_par", {31'b0, rx[0]}, 0);
`endif

        // 0x0F0F in flight; 0x5555 offered mid-frame must wait
        clr_mon();
        load(16'h0F0F);
        step(2);
        D = 16'h5555;
        LOAD_VALID = 1'b1;
        chk("t4_ready_busy", {31'b0, LOAD_READY}, 0);
        begin
            int k;
            k = 0;
            while (!DONE && k < 100) begin
                step(1);
                k++;
            end
        end
        chk("t4_done_seen", {31'b0, DONE}, 1);
        chk_data("t4_data0", 16'h0F0F);
        clr_mon();
        step(1);
        chk("t4_idle_ready", {31'b0, LOAD_READY}, 1);
        chk("t4_idle_busy", {31'b0, BUSY}, 0);
        step(1);
        chk("t4_b2b_first", {31'b0, FIRST}, 1);
        chk("t4_b2b_sv", {31'b0, SO_VALID}, 1);
        LOAD_VALID = 1'b0;
        wait_idle("t4_timeout");
        chk_data("t4_data1", 16'h5555);
        chk("t4_ndone", ndone, 1);

        // Abort 0xFFFF after bit 7
        clr_mon();
        load(16'hFFFF);
        step(6);
        chk("t5_n7", nbits, 7);
        #1 CLR = 1'b1;
        #1;
        chk("t5_sv", {31'b0, SO_VALID}, 0);
        chk("t5_so", {31'b0, SO}, 0);
        chk("t5_busy", {31'b0, BUSY}, 0);
        chk("t5_ready", {31'b0, LOAD_READY}, 1);
        step(1);
        CLR = 1'b0;
        step(3);
        chk("t5_ndone", ndone, 0);
        chk("t5_nbits", nbits, 7);

        // 0xA5A5 frame (even number of ones)
        clr_mon();
        load(16'hA5A5);
        wait_idle("t6_timeout");
        chk_data("t6_data", 16'hA5A5);
`ifdef DFF16_PISO_PARITY_EN
        chk("t6_par", {31'b0, rx[0]}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
